// File: rtl/io_dev_ctrl_pkg.sv
// io_dev_ctrl_pkg: shared types for the device-control register slave.
package io_dev_ctrl_pkg;

    typedef enum logic [3:0] {
        REG_ID         = 4'd0,
        REG_SCRATCH    = 4'd1,
        REG_CYCLE_LO   = 4'd2,
        REG_CYCLE_HI   = 4'd3,
        REG_IRQ_STATUS = 4'd4,
        REG_IRQ_MASK   = 4'd5,
        REG_GPO        = 4'd6,
        REG_GPI        = 4'd7
    } reg_idx_e;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } resp_t;

    localparam int unsigned WINDOW_BYTES = 64;

endpackage

// File: rtl/resp_fifo.sv
// resp_fifo: power-of-two response FIFO with free-running wrapping pointers.
module resp_fifo
    import io_dev_ctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  resp_t       din_i,
    input  logic        pop_i,
    output resp_t       dout_o,
    output logic [AW:0] count_o,
    output logic        full_o,
    output logic        empty_o
);

    resp_t         mem_q [DEPTH];
    logic [AW-1:0] wr_q, rd_q;
    logic [AW:0]   cnt_q;
    logic          do_push, do_pop;

    assign full_o  = cnt_q == (AW+1)'(DEPTH);
    assign empty_o = cnt_q == '0;
    assign count_o = cnt_q;
    assign dout_o  = mem_q[rd_q];
    assign do_push = push_i & ~full_o;
    assign do_pop  = pop_i & ~empty_o;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_q <= '{default: '0};
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (do_push) mem_q[wr_q] <= din_i;
            wr_q  <= wr_q + AW'(do_push);
            rd_q  <= rd_q + AW'(do_pop);
            cnt_q <= cnt_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/io_dev_ctrl_regs.sv
// io_dev_ctrl_regs: device-control register slave; access in the accept cycle,
// responses through a fixed-latency pipeline and an in-order FIFO.
module io_dev_ctrl_regs
    import io_dev_ctrl_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'hFFFF_0000,
    parameter logic [31:0] ID_VALUE     = 32'h4E55_5801,
    parameter int          RESP_LATENCY = 2,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        accept,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] rdata,
    output logic        resp_err,
    input  logic [7:0]  irq_in,
    output logic        irq_out,
    input  logic [7:0]  gpi,
    output logic [7:0]  gpo
);

    localparam int AW = $clog2(WINDOW_BYTES);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [63:0]   cyc_q;
    logic [31:0]   cyc_hi_q, cyc_hi_d, scratch_q, scratch_d;
    logic [7:0]    status_q, status_d, mask_q, mask_d, gpo_q, gpo_d, gpi_s1_q, gpi_s2_q;
    logic          irq_q;
    logic [3:0]    idx;
    logic          bad, take, wr, rd;
    resp_t         acc_r, push_r, fifo_r;
    logic          push;
    logic [2:0]    inflight;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_full, fifo_empty;

    always_comb begin
        idx         = addr[5:2];
        bad         = (addr[31:AW] != BASE_ADDR[31:AW]) | (addr[1:0] != 2'b00) | idx[3];
        take        = req & accept;
        wr          = take & we & ~bad;
        rd          = take & ~we & ~bad;
        acc_r.err   = bad;
        acc_r.rdata = '0;
        if (rd) begin
            case (idx)
                REG_ID:         acc_r.rdata = ID_VALUE;
                REG_SCRATCH:    acc_r.rdata = scratch_q;
                REG_CYCLE_LO:   acc_r.rdata = cyc_q[31:0];
                REG_CYCLE_HI:   acc_r.rdata = cyc_hi_q;
                REG_IRQ_STATUS: acc_r.rdata = {24'h0, status_q};
                REG_IRQ_MASK:   acc_r.rdata = {24'h0, mask_q};
                REG_GPO:        acc_r.rdata = {24'h0, gpo_q};
                REG_GPI:        acc_r.rdata = {24'h0, gpi_s2_q};
                default:        acc_r.rdata = '0;
            endcase
        end
        scratch_d = (wr && idx == REG_SCRATCH) ? wdata : scratch_q;
        mask_d    = (wr && idx == REG_IRQ_MASK) ? wdata[7:0] : mask_q;
        gpo_d     = (wr && idx == REG_GPO) ? wdata[7:0] : gpo_q;
        cyc_hi_d  = (rd && idx == REG_CYCLE_LO) ? cyc_q[63:32] : cyc_hi_q;
        // new sources are ORed in after the clear so a same-cycle set wins
        status_d  = (status_q & ~((wr && idx == REG_IRQ_STATUS) ? wdata[7:0] : 8'h0)) | irq_in;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_q     <= '0;
            cyc_hi_q  <= '0;
            scratch_q <= '0;
            status_q  <= '0;
            mask_q    <= '0;
            gpo_q     <= '0;
            gpi_s1_q  <= '0;
            gpi_s2_q  <= '0;
            irq_q     <= 1'b0;
        end else begin
            cyc_q     <= cyc_q + 64'd1;
            cyc_hi_q  <= cyc_hi_d;
            scratch_q <= scratch_d;
            status_q  <= status_d;
            mask_q    <= mask_d;
            gpo_q     <= gpo_d;
            gpi_s1_q  <= gpi;
            gpi_s2_q  <= gpi_s1_q;
            irq_q     <= |(status_q & mask_q);
        end
    end

    // the FIFO write itself supplies the final cycle of latency
    generate
        if (RESP_LATENCY == 1) begin : g_direct
            assign push     = take;
            assign push_r   = acc_r;
            assign inflight = '0;
        end else begin : g_pipe
            logic [RESP_LATENCY-2:0] v_q;
            resp_t                   r_q [RESP_LATENCY-1];
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    v_q <= '0;
                    r_q <= '{default: '0};
                end else begin
                    v_q[0] <= take;
                    r_q[0] <= acc_r;
                    for (int i = 1; i < RESP_LATENCY - 1; i++) begin
                        v_q[i] <= v_q[i-1];
                        r_q[i] <= r_q[i-1];
                    end
                end
            end
            assign push     = v_q[RESP_LATENCY-2];
            assign push_r   = r_q[RESP_LATENCY-2];
            assign inflight = 3'($countones(v_q));
        end
    endgenerate

    resp_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .din_i   (push_r),
        .pop_i   (resp_valid & resp_ready),
        .dout_o  (fifo_r),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign accept     = ~reset & ~fifo_full & ((int'(inflight) + int'(fifo_cnt)) < FIFO_DEPTH);
    assign resp_valid = ~fifo_empty;
    assign rdata      = resp_valid ? fifo_r.rdata : '0;
    assign resp_err   = resp_valid & fifo_r.err;
    assign irq_out    = irq_q;
    assign gpo        = gpo_q;

endmodule
